// File: rtl/gem_clct_window_builder_pkg.sv
// Shared constants, FSM encoding and the delta-to-magnitude helper for the
// GEM-CLCT window builder.
package gem_clct_window_builder_pkg;

   localparam int MXXKY = 10;
   localparam int NSLOT = 8;

   localparam logic [MXXKY-1:0] PRI_NULL = 10'h3FF;
   localparam logic [MXXKY-1:0] PRI_SAT  = 10'h3FE;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIFF = 2'd1,
      ST_OUT  = 2'd2
   } state_e;

   // |delta| always fits in MXXKY bits because both operands are MXXKY-bit unsigned.
   function automatic logic [MXXKY-1:0] abs_delta(input logic [MXXKY:0] d);
      return d[MXXKY] ? (~d[MXXKY-1:0] + 10'd1) : d[MXXKY-1:0];
   endfunction

endpackage

// File: rtl/gem_clct_absdiff.sv
// Per-slot bending-angle stage: magnitude, window compare, null/saturate
// selection, registered when the builder is in OUT.
module gem_clct_absdiff
   import gem_clct_window_builder_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [MXXKY:0]   delta_i,
   input  logic             slot_vld_i,
   input  logic [MXXKY-1:0] slot_xky_i,
   input  logic [MXXKY-1:0] win_i,
   output logic [MXXKY-1:0] pri_o,
   output logic [MXXKY-1:0] xky_o
);

   logic [MXXKY-1:0] abs_s;
   logic [MXXKY-1:0] pri_d, pri_q;
   logic [MXXKY-1:0] xky_d, xky_q;

   always_comb begin
      abs_s = abs_delta(delta_i);
      pri_d = PRI_NULL;
      xky_d = 10'd0;
      // A valid in-window slot must never tie with the null priority.
      if (slot_vld_i && (abs_s <= win_i)) begin
         pri_d = (abs_s == PRI_NULL) ? PRI_SAT : abs_s;
         xky_d = slot_xky_i;
      end else begin
         pri_d = PRI_NULL;
         xky_d = 10'd0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pri_q <= PRI_NULL;
         xky_q <= 10'd0;
      end else if (load_i) begin
         pri_q <= pri_d;
         xky_q <= xky_d;
      end else begin
         pri_q <= pri_q;
         xky_q <= xky_q;
      end
   end

   assign pri_o = pri_q;
   assign xky_o = xky_q;

endmodule

// File: rtl/gem_clct_window_builder.sv
// GEM cluster slot buffer plus snapshot/delta/output pipeline that feeds the
// smallest-angle encoder with 8 priority/xky pairs per CLCT trigger.
module gem_clct_window_builder
   import gem_clct_window_builder_pkg::*;
(
   input  logic                     clock,
   input  logic                     global_reset,
   input  logic                     gem_vld,
   input  logic [MXXKY-1:0]         gem_xky,
   input  logic                     gem_clr,
   input  logic                     clct_vpf,
   input  logic [MXXKY-1:0]         clct_xky,
   input  logic [MXXKY-1:0]         match_win,
   output logic [NSLOT*MXXKY-1:0]   win_pri,
   output logic [NSLOT*MXXKY-1:0]   gem_xky_out,
   output logic                     pri_vld,
   output logic                     busy,
   output logic                     clct_drop,
   output logic [3:0]               gem_cnt,
   output logic                     gem_ovf
);

   state_e           state_q, state_d;
   logic [MXXKY-1:0] slot_xky_q [NSLOT];
   logic [MXXKY-1:0] slot_xky_d [NSLOT];
   logic [NSLOT-1:0] slot_vld_q, slot_vld_d;
   logic [3:0]       gem_cnt_q, gem_cnt_d;
   logic             gem_ovf_q, gem_ovf_d;

   logic [MXXKY-1:0] snap_xky_q [NSLOT];
   logic [NSLOT-1:0] snap_vld_q;
   logic [MXXKY-1:0] snap_clct_q;
   logic [MXXKY-1:0] snap_win_q;
   logic [MXXKY:0]   delta_q [NSLOT];

   logic             pri_vld_q, busy_q, clct_drop_q;

   // Clear takes effect before a same-cycle write, so that write lands in slot 0.
   always_comb begin
      slot_xky_d = slot_xky_q;
      slot_vld_d = slot_vld_q;
      gem_cnt_d  = gem_cnt_q;
      gem_ovf_d  = gem_ovf_q;
      if (gem_clr) begin
         slot_vld_d = '0;
         gem_cnt_d  = 4'd0;
         gem_ovf_d  = 1'b0;
      end else begin
         gem_cnt_d  = gem_cnt_q;
      end
      if (gem_vld) begin
         if (gem_cnt_d < 4'(NSLOT)) begin
            slot_xky_d[gem_cnt_d[2:0]] = gem_xky;
            slot_vld_d[gem_cnt_d[2:0]] = 1'b1;
            gem_cnt_d                  = gem_cnt_d + 4'd1;
         end else begin
            gem_ovf_d = 1'b1;
         end
      end else begin
         gem_ovf_d = gem_ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (clct_vpf) state_d = ST_DIFF; else state_d = ST_IDLE;
         ST_DIFF: state_d = ST_OUT;
         ST_OUT:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (global_reset) begin
         state_q     <= ST_IDLE;
         slot_vld_q  <= '0;
         gem_cnt_q   <= 4'd0;
         gem_ovf_q   <= 1'b0;
         pri_vld_q   <= 1'b0;
         busy_q      <= 1'b0;
         clct_drop_q <= 1'b0;
         for (int k = 0; k < NSLOT; k++) slot_xky_q[k] <= 10'd0;
      end else begin
         state_q     <= state_d;
         slot_xky_q  <= slot_xky_d;
         slot_vld_q  <= slot_vld_d;
         gem_cnt_q   <= gem_cnt_d;
         gem_ovf_q   <= gem_ovf_d;
         pri_vld_q   <= (state_q == ST_OUT);
         busy_q      <= (state_d != ST_IDLE);
         clct_drop_q <= clct_vpf && (state_q != ST_IDLE);
      end
   end

   // Snapshot decouples the in-flight compute from later buffer traffic.
   always_ff @(posedge clock) begin
      if (global_reset) begin
         snap_vld_q  <= '0;
         snap_clct_q <= 10'd0;
         snap_win_q  <= 10'd0;
         for (int k = 0; k < NSLOT; k++) begin
            snap_xky_q[k] <= 10'd0;
            delta_q[k]    <= 11'd0;
         end
      end else begin
         if ((state_q == ST_IDLE) && clct_vpf) begin
            snap_xky_q  <= slot_xky_q;
            snap_vld_q  <= slot_vld_q;
            snap_clct_q <= clct_xky;
            snap_win_q  <= match_win;
         end
         if (state_q == ST_DIFF) begin
            for (int k = 0; k < NSLOT; k++)
               delta_q[k] <= {1'b0, snap_xky_q[k]} - {1'b0, snap_clct_q};
         end
      end
   end

   for (genvar k = 0; k < NSLOT; k++) begin : g_slot
      gem_clct_absdiff u_absdiff (
         .clk_i      (clock),
         .rst_i      (global_reset),
         .load_i     (state_q == ST_OUT),
         .delta_i    (delta_q[k]),
         .slot_vld_i (snap_vld_q[k]),
         .slot_xky_i (snap_xky_q[k]),
         .win_i      (snap_win_q),
         .pri_o      (win_pri[k*MXXKY +: MXXKY]),
         .xky_o      (gem_xky_out[k*MXXKY +: MXXKY])
      );
   end

   assign pri_vld   = pri_vld_q;
   assign busy      = busy_q;
   assign clct_drop = clct_drop_q;
   assign gem_cnt   = gem_cnt_q;
   assign gem_ovf   = gem_ovf_q;

endmodule

// File: tb/tb_gem_clct_window_builder.sv
// Scoreboard bench: a behavioural buffer/window model predicts every strobe,
// status output and held output value cycle by cycle.
module tb_gem_clct_window_builder;

   logic        clock = 1'b0;
   logic        global_reset, gem_vld, gem_clr, clct_vpf;
   logic [9:0]  gem_xky, clct_xky, match_win;
   logic [79:0] win_pri, gem_xky_out;
   logic        pri_vld, busy, clct_drop, gem_ovf;
   logic [3:0]  gem_cnt;

   always #5 clock = ~clock;

   gem_clct_window_builder dut (
      .clock(clock), .global_reset(global_reset), .gem_vld(gem_vld), .gem_xky(gem_xky),
      .gem_clr(gem_clr), .clct_vpf(clct_vpf), .clct_xky(clct_xky), .match_win(match_win),
      .win_pri(win_pri), .gem_xky_out(gem_xky_out), .pri_vld(pri_vld), .busy(busy),
      .clct_drop(clct_drop), .gem_cnt(gem_cnt), .gem_ovf(gem_ovf)
   );

   typedef struct {
      logic [79:0] pri;
      logic [79:0] xky;
      int          due;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          edge_cnt = 0;
   int          m_busy   = 0;
   int          m_cnt    = 0;
   logic        m_ovf    = 1'b0;
   logic [9:0]  m_xky [8];
   logic [7:0]  m_vld    = 8'h00;
   logic [79:0] last_pri = {8{10'h3FF}};
   logic [79:0] last_xky = 80'd0;

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model_expect(input logic [9:0] cx, input logic [9:0] win);
      exp_t e;
      int   d;
      e.pri = {8{10'h3FF}};
      e.xky = 80'd0;
      e.due = 0;
      for (int k = 0; k < 8; k++) begin
         if (m_vld[k]) begin
            d = int'(m_xky[k]) - int'(cx);
            if (d < 0) d = -d;
            if (d <= int'(win)) begin
               e.pri[k*10 +: 10] = (d == 1023) ? 10'h3FE : 10'(d);
               e.xky[k*10 +: 10] = m_xky[k];
            end
         end
      end
      return e;
   endfunction

   task automatic monitor(input logic exp_drop);
      exp_t e;
      check("busy", 80'(busy), 80'(m_busy != 0));
      check("clct_drop", 80'(clct_drop), 80'(exp_drop));
      check("gem_cnt", 80'(gem_cnt), 80'(m_cnt));
      check("gem_ovf", 80'(gem_ovf), 80'(m_ovf));
      if (pri_vld) begin
         if (sb_q.size() == 0) begin
            check("pri_vld_spurious", 80'd1, 80'd0);
         end else begin
            e = sb_q.pop_front();
            check("pri_vld_latency", 80'(edge_cnt), 80'(e.due));
            last_pri = e.pri;
            last_xky = e.xky;
         end
      end else if (sb_q.size() != 0 && sb_q[0].due <= edge_cnt) begin
         check("pri_vld_missing", 80'd0, 80'd1);
         e = sb_q.pop_front();
      end
      check("win_pri", win_pri, last_pri);
      check("gem_xky_out", gem_xky_out, last_xky);
   endtask

   task automatic tick(input logic vld, input logic [9:0] xky, input logic clr,
                       input logic vpf, input logic [9:0] cx, input logic [9:0] win);
      exp_t e;
      logic exp_drop;
      global_reset = 1'b0;
      gem_vld = vld; gem_xky = xky; gem_clr = clr;
      clct_vpf = vpf; clct_xky = cx; match_win = win;
      exp_drop = vpf && (m_busy != 0);
      if (vpf && m_busy == 0) begin
         e = model_expect(cx, win);
         e.due = edge_cnt + 3;
         sb_q.push_back(e);
         m_busy = 2;
      end else if (m_busy != 0) begin
         m_busy--;
      end
      if (clr) begin
         m_cnt = 0; m_vld = 8'h00; m_ovf = 1'b0;
      end
      if (vld) begin
         if (m_cnt < 8) begin
            m_xky[m_cnt] = xky; m_vld[m_cnt] = 1'b1; m_cnt++;
         end else begin
            m_ovf = 1'b1;
         end
      end
      @(negedge clock);
      edge_cnt++;
      monitor(exp_drop);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 10'd0);
   endtask

   task automatic do_reset();
      global_reset = 1'b1;
      gem_vld = 1'b0; gem_xky = 10'd0; gem_clr = 1'b0;
      clct_vpf = 1'b0; clct_xky = 10'd0; match_win = 10'd0;
      @(negedge clock);
      edge_cnt++;
      global_reset = 1'b0;
      sb_q.delete();
      m_busy = 0; m_cnt = 0; m_vld = 8'h00; m_ovf = 1'b0;
      last_pri = {8{10'h3FF}};
      last_xky = 80'd0;
      monitor(1'b0);
   endtask

   initial begin
      global_reset = 1'b1;
      gem_vld = 1'b0; gem_xky = 10'd0; gem_clr = 1'b0;
      clct_vpf = 1'b0; clct_xky = 10'd0; match_win = 10'd0;
      for (int k = 0; k < 8; k++) m_xky[k] = 10'd0;
      @(negedge clock);
      do_reset();
      do_reset();

      // Basic window match across three clusters
      tick(1'b1, 10'd100, 1'b0, 1'b0, 10'd0, 10'd0);
      tick(1'b1, 10'd120, 1'b0, 1'b0, 10'd0, 10'd0);
      tick(1'b1, 10'd90,  1'b0, 1'b0, 10'd0, 10'd0);
      tick(1'b0, 10'd0,   1'b0, 1'b1, 10'd105, 10'd20);
      idle(3);

      // Out-of-window cluster
      tick(1'b1, 10'd200, 1'b1, 1'b0, 10'd0, 10'd0);
      tick(1'b0, 10'd0,   1'b0, 1'b1, 10'd150, 10'd20);
      idle(3);

      // Overflow, then clear-with-write
      tick(1'b0, 10'd0, 1'b1, 1'b0, 10'd0, 10'd0);
      for (int i = 0; i < 9; i++) tick(1'b1, 10'(11 * i + 3), 1'b0, 1'b0, 10'd0, 10'd0);
      tick(1'b0, 10'd0, 1'b0, 1'b1, 10'd0, 10'd1023);
      idle(3);
      tick(1'b1, 10'd7, 1'b1, 1'b0, 10'd0, 10'd0);
      tick(1'b0, 10'd0, 1'b0, 1'b1, 10'd7, 10'd0);
      idle(3);

      // Saturation at |delta| = 1023 from both directions
      tick(1'b1, 10'd1023, 1'b1, 1'b0, 10'd0, 10'd0);
      tick(1'b1, 10'd0,    1'b0, 1'b0, 10'd0, 10'd0);
      tick(1'b0, 10'd0,    1'b0, 1'b1, 10'd0, 10'd1023);
      idle(2);
      tick(1'b0, 10'd0,    1'b0, 1'b1, 10'd1023, 10'd1023);
      idle(3);

      // Trigger while busy, then re-trigger three cycles after the first
      tick(1'b0, 10'd0, 1'b0, 1'b1, 10'd500, 10'd600);
      tick(1'b0, 10'd0, 1'b0, 1'b1, 10'd1,   10'd1);
      tick(1'b0, 10'd0, 1'b0, 1'b0, 10'd0,   10'd0);
      tick(1'b0, 10'd0, 1'b0, 1'b1, 10'd1000, 10'd30);
      idle(3);

      // Buffer traffic during DIFF must not reach the in-flight result
      tick(1'b1, 10'd50, 1'b1, 1'b0, 10'd0,  10'd0);
      tick(1'b0, 10'd0,  1'b0, 1'b1, 10'd40, 10'd100);
      tick(1'b1, 10'd60, 1'b1, 1'b0, 10'd0,  10'd0);
      idle(3);
      tick(1'b0, 10'd0,  1'b0, 1'b1, 10'd40, 10'd100);
      idle(3);

      // Reset during DIFF aborts the compute
      tick(1'b1, 10'd33, 1'b0, 1'b0, 10'd0,  10'd0);
      tick(1'b0, 10'd0,  1'b0, 1'b1, 10'd30, 10'd10);
      do_reset();
      idle(4);

      // Random traffic
      for (int i = 0; i < 200; i++)
         tick(1'($urandom_range(0, 2) != 0), 10'($urandom_range(0, 1023)),
              1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) == 0),
              10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
      idle(5);
      check("scoreboard_drained", 80'(sb_q.size()), 80'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
